// File: rtl/cvita_stream_checker.sv
// CVITA stream checker: one-deep register slice that forwards beats unchanged while
// checking seqnum continuity and header length against beat count per packet.
module cvita_stream_checker #(
   parameter int CHECK_ALL_TYPES = 0,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic [63:0]          i_tdata,
   input  logic                 i_tlast,
   input  logic                 i_tvalid,
   output logic                 i_tready,
   output logic [63:0]          o_tdata,
   output logic                 o_tlast,
   output logic                 o_tvalid,
   input  logic                 o_tready,
   output logic [31:0]          pkt_cnt,
   output logic [CNT_WIDTH-1:0] seq_err_cnt,
   output logic [CNT_WIDTH-1:0] len_err_cnt,
   output logic                 err_stb,
   output logic                 err_seq,
   output logic                 err_len,
   output logic [11:0]          expected_seqnum,
   output logic [31:0]          last_sid
);

   typedef enum logic [1:0] {HDR, BODY, SKIP} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        seq_valid;
   logic [13:0] beats_q, beat_cnt;
   logic        time_q, seq_bad_q;

   logic [1:0]  hdr_type;
   logic        hdr_time;
   logic [11:0] hdr_seq;
   logic [13:0] hdr_beats;
   logic        seq_applies, hdr_seq_bad;

   logic [13:0] cur_beats, cur_cnt;
   logic        cur_time, cur_seq_bad, len_bad, pkt_end;

   assign i_tready = ~o_tvalid | o_tready;
   assign accept   = i_tvalid & i_tready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_tvalid <= 1'b0;
         o_tdata  <= '0;
         o_tlast  <= 1'b0;
      end else if (accept) begin
         o_tvalid <= 1'b1;
         o_tdata  <= i_tdata;
         o_tlast  <= i_tlast;
      end else if (o_tready) begin
         o_tvalid <= 1'b0;
      end
   end

   assign hdr_type    = i_tdata[63:62];
   assign hdr_time    = i_tdata[61];
   assign hdr_seq     = i_tdata[59:48];
   assign hdr_beats   = 14'(({1'b0, i_tdata[47:32]} + 17'd7) >> 3);
   assign seq_applies = (CHECK_ALL_TYPES != 0) || (hdr_type == 2'b00);
   assign hdr_seq_bad = seq_applies && seq_valid && (hdr_seq != expected_seqnum);

   // A single-beat packet ends on its header, so header fields are used directly in HDR.
   always_comb begin
      cur_beats   = beats_q;
      cur_time    = time_q;
      cur_seq_bad = seq_bad_q;
      cur_cnt     = (beat_cnt == 14'h3FFF) ? beat_cnt : beat_cnt + 14'd1;
      if (state == HDR) begin
         cur_beats   = hdr_beats;
         cur_time    = hdr_time;
         cur_seq_bad = hdr_seq_bad;
         cur_cnt     = 14'd1;
      end
      len_bad = (cur_cnt != cur_beats) || (cur_time && cur_beats < 14'd2) || (cur_beats == 14'd0);
      pkt_end = accept && i_tlast && (state != SKIP) && !clear;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         if (accept && i_tlast)  state_nxt = HDR;
         else if (state == BODY) state_nxt = SKIP;
      end else if (accept) begin
         case (state)
            HDR:     if (!i_tlast) state_nxt = BODY;
            BODY:    if (i_tlast)  state_nxt = HDR;
            SKIP:    if (i_tlast)  state_nxt = HDR;
            default: state_nxt = HDR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= HDR;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seq_valid       <= 1'b0;
         expected_seqnum <= '0;
         last_sid        <= '0;
         beats_q         <= '0;
         beat_cnt        <= '0;
         time_q          <= 1'b0;
         seq_bad_q       <= 1'b0;
         pkt_cnt         <= '0;
         seq_err_cnt     <= '0;
         len_err_cnt     <= '0;
         err_stb         <= 1'b0;
         err_seq         <= 1'b0;
         err_len         <= 1'b0;
      end else if (clear) begin
         seq_valid       <= 1'b0;
         expected_seqnum <= '0;
         pkt_cnt         <= '0;
         seq_err_cnt     <= '0;
         len_err_cnt     <= '0;
         err_stb         <= 1'b0;
         err_seq         <= 1'b0;
         err_len         <= 1'b0;
      end else begin
         err_stb <= pkt_end;
         if (accept && state == HDR) begin
            beats_q   <= hdr_beats;
            time_q    <= hdr_time;
            seq_bad_q <= hdr_seq_bad;
            last_sid  <= i_tdata[31:0];
            beat_cnt  <= 14'd1;
            // Always resync to the received seqnum so one gap yields one error.
            if (seq_applies) begin
               expected_seqnum <= hdr_seq + 12'd1;
               seq_valid       <= 1'b1;
            end
         end else if (accept && state == BODY) begin
            beat_cnt <= cur_cnt;
         end
         if (pkt_end) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            err_seq <= cur_seq_bad;
            err_len <= len_bad;
            if (cur_seq_bad && seq_err_cnt != '1) seq_err_cnt <= seq_err_cnt + 1'b1;
            if (len_bad && len_err_cnt != '1)     len_err_cnt <= len_err_cnt + 1'b1;
         end
      end
   end

endmodule
